// File: rtl/ov7670_mem_controller.sv
// OV7670 capture front end: assembles RGB565 pixels from the camera byte stream
// and writes them to a linear frame buffer, reporting whether each frame was well formed.
module ov7670_mem_controller #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        href,
    input  logic        vsync,
    input  logic [7:0]  data,
    output logic        we,
    output logic [16:0] wAddr,
    output logic [15:0] wData,
    output logic        frame_done,
    output logic        frame_ok
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H);
    localparam logic [16:0]   W17   = 17'(IMG_W);

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_START,
        ACTIVE
    } state_t;

    state_t         state_q, state_d;
    logic           href_s1_q, href_s1_d, vsync_s1_q, vsync_s1_d;
    logic [7:0]     data_s1_q, data_s1_d;
    logic           href_s2_q, href_s2_d, vsync_s2_q, vsync_s2_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    logic           bad_q, bad_d;
    logic           we_q, we_d;
    logic [16:0]    waddr_q, waddr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_ok_q, frame_ok_d;

    logic           vs_rise, vs_fall, href_fall;
    logic [16:0]    pix_addr;

    // Edges come from the synchronised stage and its one-cycle-old copy.
    assign vs_rise   = vsync_s1_q & ~vsync_s2_q;
    assign vs_fall   = ~vsync_s1_q & vsync_s2_q;
    assign href_fall = ~href_s1_q & href_s2_q;
    assign pix_addr  = 17'(y_q) * W17 + 17'(x_q);

    always_comb begin
        state_d      = state_q;
        href_s1_d    = href;
        vsync_s1_d   = vsync;
        data_s1_d    = data;
        href_s2_d    = href_s1_q;
        vsync_s2_d   = vsync_s1_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        bad_d        = bad_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;

        case (state_q)
            WAIT_VS: begin
                if (vsync_s1_q) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            ACTIVE: begin
                // A frame end in the same cycle as a byte drops that byte.
                if (vs_rise) begin
                    state_d      = WAIT_START;
                    frame_done_d = 1'b1;
                    frame_ok_d   = (y_q == Y_MAX) && !bad_q;
                end else if (href_s1_q) begin
                    if (!phase_q) begin
                        hi_d    = data_s1_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
                            we_d    = 1'b1;
                            waddr_d = pix_addr;
                            wdata_d = {hi_q, data_s1_q};
                        end else begin
                            bad_d = 1'b1;
                        end
                        if (x_q != X_MAX) x_d = x_q + XW'(1);
                    end
                end else if (href_fall) begin
                    if (phase_q || (x_q != X_MAX)) bad_d = 1'b1;
                    if (y_q != Y_MAX) y_d = y_q + YW'(1);
                    x_d     = '0;
                    phase_d = 1'b0;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q      <= WAIT_VS;
            href_s1_q    <= 1'b0;
            vsync_s1_q   <= 1'b0;
            data_s1_q    <= '0;
            href_s2_q    <= 1'b0;
            vsync_s2_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            bad_q        <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            href_s1_q    <= href_s1_d;
            vsync_s1_q   <= vsync_s1_d;
            data_s1_q    <= data_s1_d;
            href_s2_q    <= href_s2_d;
            vsync_s2_q   <= vsync_s2_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            bad_q        <= bad_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
        end
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;

endmodule

// File: tb/tb_ov7670_mem_controller.sv
// Bench for ov7670_mem_controller: a 4x2 instance for the frame-shape cases and a
// default-size instance for the full-address case, both checked against a write scoreboard.
module tb_ov7670_mem_controller;

    localparam int SW = 4;
    localparam int SH = 2;
    localparam int BW = 320;
    localparam int BH = 240;
    localparam int WR_W = 33;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       reset_n, href, vsync, sel;
    logic [7:0] data;

    logic        href_a, vsync_a, href_b, vsync_b;
    logic        we_a, frame_done_a, frame_ok_a, we_b, frame_done_b, frame_ok_b;
    logic [16:0] wAddr_a, wAddr_b;
    logic [15:0] wData_a, wData_b;
    logic        fd_m, fok_m;

    // sel routes the camera stimulus to one instance; the other sees an idle bus.
    assign href_a  = sel ? 1'b0 : href;
    assign vsync_a = sel ? 1'b0 : vsync;
    assign href_b  = sel ? href : 1'b0;
    assign vsync_b = sel ? vsync : 1'b0;
    assign fd_m    = sel ? frame_done_b : frame_done_a;
    assign fok_m   = sel ? frame_ok_b : frame_ok_a;

    ov7670_mem_controller #(.IMG_W(SW), .IMG_H(SH)) dut_small (
        .pclk(pclk), .reset_n(reset_n), .href(href_a), .vsync(vsync_a), .data(data),
        .we(we_a), .wAddr(wAddr_a), .wData(wData_a),
        .frame_done(frame_done_a), .frame_ok(frame_ok_a)
    );

    ov7670_mem_controller dut_big (
        .pclk(pclk), .reset_n(reset_n), .href(href_b), .vsync(vsync_b), .data(data),
        .we(we_b), .wAddr(wAddr_b), .wData(wData_b),
        .frame_done(frame_done_b), .frame_ok(frame_ok_b)
    );

    // Scoreboard: {addr, data} per expected write.
    logic [WR_W-1:0] exp_q[$];
    logic [WR_W-1:0] exp_b_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    logic [16:0] hold_addr = '0;
    logic [15:0] hold_data = '0;
    logic [16:0] last_b_addr = '0;
    logic        mon_en = 1'b0;
    int          m_y = 0;
    bit          m_bad = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge pclk) begin
        if (mon_en) begin
            if (we_a !== 1'b0) begin
                check("write_a_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    logic [WR_W-1:0] e;
                    e = exp_q.pop_front();
                    check("write_a_addr", 64'(wAddr_a), 64'(e[32:16]));
                    check("write_a_data", 64'(wData_a), 64'(e[15:0]));
                    hold_addr = e[32:16];
                    hold_data = e[15:0];
                end
            end else begin
                check("hold_a_addr", 64'(wAddr_a), 64'(hold_addr));
                check("hold_a_data", 64'(wData_a), 64'(hold_data));
            end
        end
    end

    always @(negedge pclk) begin
        if (mon_en && (we_b !== 1'b0)) begin
            check("write_b_expected", 64'(exp_b_q.size() != 0), 64'd1);
            if (exp_b_q.size() != 0) begin
                logic [WR_W-1:0] e;
                e = exp_b_q.pop_front();
                check("write_b_addr", 64'(wAddr_b), 64'(e[32:16]));
                check("write_b_data", 64'(wData_b), 64'(e[15:0]));
            end
            last_b_addr = wAddr_b;
        end
    end

    task automatic drive_bytes(input int n, input int start);
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            href = 1'b1;
            data = 8'(start + k);
        end
        @(negedge pclk);
        href = 1'b0;
        data = 8'h00;
        repeat (3) @(negedge pclk);
    endtask

    task automatic send_line(input int n, input int start);
        int w, h, pix;
        logic [WR_W-1:0] e;
        w   = sel ? BW : SW;
        h   = sel ? BH : SH;
        pix = n / 2;
        for (int i = 0; i < pix; i++) begin
            if (i < w && m_y < h) begin
                e = {17'(m_y * w + i), 8'(start + 2 * i), 8'(start + 2 * i + 1)};
                if (sel) exp_b_q.push_back(e);
                else     exp_q.push_back(e);
            end
        end
        if (pix != w || (n % 2) != 0 || (m_y >= h && pix > 0)) m_bad = 1'b1;
        if (m_y < h) m_y++;
        drive_bytes(n, start);
    endtask

    task automatic vsync_pulse(input int exp_done, input int exp_ok, input string tag);
        int pulses;
        pulses = 0;
        check({tag, "_pending_writes"}, 64'(sel ? exp_b_q.size() : exp_q.size()), 64'd0);
        @(negedge pclk);
        vsync = 1'b1;
        repeat (6) begin
            @(negedge pclk);
            if (fd_m === 1'b1) pulses++;
        end
        check({tag, "_done_pulses"}, 64'(pulses), 64'(exp_done));
        check({tag, "_frame_ok"}, 64'(fok_m), 64'(exp_ok));
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
        m_y   = 0;
        m_bad = 1'b0;
    endtask

    initial begin
        int r1, r2;
        sel     = 1'b0;
        href    = 1'b0;
        vsync   = 1'b0;
        data    = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_we", 64'(we_a), 64'd0);
        check("rst_waddr", 64'(wAddr_a), 64'd0);
        check("rst_wdata", 64'(wData_a), 64'd0);
        check("rst_frame_done", 64'(frame_done_a), 64'd0);
        check("rst_frame_ok", 64'(frame_ok_a), 64'd0);
        check("rst_we_big", 64'(we_b), 64'd0);
        check("rst_waddr_big", 64'(wAddr_b), 64'd0);
        mon_en  = 1'b1;
        reset_n = 1'b1;

        // href before any vsync must be ignored.
        drive_bytes(8, 8'h40);
        vsync_pulse(0, 0, "first_vs");

        send_line(8, 8'h00);
        send_line(8, 8'h08);
        vsync_pulse(1, 1, "nominal");

        send_line(8, 8'h10);
        send_line(6, 8'h20);
        vsync_pulse(1, 0, "short_line");

        send_line(8, 8'h30);
        send_line(8, 8'h40);
        send_line(8, 8'h50);
        vsync_pulse(1, 0, "extra_line");

        send_line(9, 8'h60);
        send_line(8, 8'h70);
        vsync_pulse(1, 0, "odd_bytes");

        r1 = $urandom_range(0, 255);
        r2 = $urandom_range(0, 255);
        send_line(8, r1);
        send_line(8, r2);
        vsync_pulse(1, 1, "random_frame");

        // Reset during line 0 after one completed pixel.
        exp_q.push_back({17'd0, 8'h00, 8'h01});
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            href = 1'b1;
            data = 8'(k);
        end
        @(negedge pclk);
        data    = 8'h03;
        reset_n = 1'b0;
        @(posedge pclk);
        #1;
        hold_addr = '0;
        hold_data = '0;
        @(negedge pclk);
        reset_n = 1'b1;
        check("midrst_we", 64'(we_a), 64'd0);
        check("midrst_waddr", 64'(wAddr_a), 64'd0);
        check("midrst_frame_done", 64'(frame_done_a), 64'd0);
        for (int k = 4; k < 8; k++) begin
            data = 8'(k);
            @(negedge pclk);
        end
        href = 1'b0;
        repeat (3) @(negedge pclk);
        drive_bytes(8, 8'h88);
        vsync_pulse(0, 0, "post_reset");
        send_line(8, 8'hA0);
        send_line(8, 8'hB0);
        vsync_pulse(1, 1, "restart");

        // Default-size instance: short lines down to the last row, then a full last row.
        sel = 1'b1;
        vsync_pulse(0, 0, "big_start");
        for (int y = 0; y < BH - 1; y++) send_line(2, y);
        send_line(2 * BW, 0);
        vsync_pulse(1, 0, "big_end");
        check("big_last_addr", 64'(last_b_addr), 64'd76799);
        check("small_queue_empty", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
